sta_frame_tx: RTL and testbench

//  Drives one graph frame into the STA block over its in_valid/delay/source/destination input

---
 rtl/sta_frame_tx_if.sv | 21 ++
 rtl/sta_frame_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_sta_frame_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sta_frame_tx_if.sv
// sta_frame_tx_if: frame/result link between the frame transmitter and the STA block.
// master = transmitter side (drives the frame), slave = STA side (drives the result).
interface sta_frame_tx_if;
  logic       in_valid;
  logic [3:0] delay;
  logic [3:0] source;
  logic [3:0] destination;
  logic       out_valid;
  logic [7:0] worst_delay;
  logic [3:0] path;

  modport master (
    output in_valid, delay, source, destination,
    input  out_valid, worst_delay, path
  );

  modport slave (
    input  in_valid, delay, source, destination,
    output out_valid, worst_delay, path
  );
endinterface

// File: rtl/sta_frame_tx.sv
// sta_frame_tx: on-chip stimulus engine for the STA block. Preloaded delay and
// edge tables are streamed out as one frame per start, then the returning
// result stream is captured (first worst_delay, run length) with a timeout.
// Optional feature macro: STA_TX_PATH_CHECK_EN (result path protocol check).
//
// state | meaning
// IDLE  | waiting for start; tables writable
// SEND  | streaming EDGES contiguous frame cycles to STA
// WAIT  | awaiting / capturing the result; response timer running
// DONE  | single completion cycle, done pulse
module sta_frame_tx #(
  parameter int NODES   = 16,
  parameter int EDGES   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_wr_en,
  input  logic           i_wr_sel,
  input  logic [4:0]     i_wr_addr,
  input  logic [7:0]     i_wr_data,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_timeout_err,
  output logic [7:0]     o_res_delay,
  output logic [4:0]     o_res_len,
  output logic           o_path_err,
  sta_frame_tx_if.master sta
);

  localparam int KW = (EDGES > 1) ? $clog2(EDGES) : 1;
  localparam int NW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_dly  [NODES];
  logic [7:0]      r_edge [EDGES];
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   w_idx;
  logic [TW-1:0]   r_tmr;
  logic            r_got;
  logic            r_in_valid;
  logic [3:0]      r_delay;
  logic [3:0]      r_source;
  logic [3:0]      r_destination;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout_err;
  logic [7:0]      r_res_delay;
  logic [4:0]      r_res_len;
  logic            w_accept;
  logic            w_send_last;
  logic            w_first;
  logic            w_more;
  logic            w_fall;
  logic            w_expire;

  // Next-state decode plus the per-cycle events the datapath reacts to.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_send_last = 1'b0;
    w_first     = 1'b0;
    w_more      = 1'b0;
    w_fall      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_wr_en) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (r_k == KW'(EDGES - 1)) begin
          w_send_last = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sta.out_valid) begin
          if (!r_got) w_first = 1'b1;
          else        w_more  = 1'b1;
        end else if (r_got) begin
          w_fall      = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_tmr == '0) begin
          w_expire    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Table write port, only open while idle; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) r_dly[i]  <= '0;
      for (int i = 0; i < EDGES; i++) r_edge[i] <= '0;
    end else if (r_state == S_IDLE && i_wr_en) begin
      if (!i_wr_sel && int'(i_wr_addr) < NODES) r_dly[i_wr_addr[NW-1:0]]  <= i_wr_data[3:0];
      if (i_wr_sel && int'(i_wr_addr) < EDGES)  r_edge[i_wr_addr[KW-1:0]] <= i_wr_data;
    end
  end

  assign w_idx = w_accept ? '0 : (r_k + KW'(1));

  // Frame outputs are registered one cycle ahead of the frame index they carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k           <= '0;
      r_in_valid    <= 1'b0;
      r_delay       <= '0;
      r_source      <= '0;
      r_destination <= '0;
    end else if (w_accept || (r_state == S_SEND && !w_send_last)) begin
      r_k           <= w_idx;
      r_in_valid    <= 1'b1;
      r_delay       <= (int'(w_idx) < NODES) ? r_dly[w_idx[NW-1:0]] : 4'd0;
      r_source      <= r_edge[w_idx][7:4];
      r_destination <= r_edge[w_idx][3:0];
    end else begin
      r_k           <= '0;
      r_in_valid    <= 1'b0;
      r_delay       <= '0;
      r_source      <= '0;
      r_destination <= '0;
    end
  end

  // Response timer: loaded as the frame ends, counts down until the first result cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmr <= '0;
    else if (w_send_last)
      r_tmr <= TW'(TIMEOUT - 1);
    else if (r_state == S_WAIT && !r_got && !sta.out_valid && r_tmr != '0)
      r_tmr <= r_tmr - TW'(1);
  end

  // Result capture; everything is cleared by an accepted start and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_got         <= 1'b0;
      r_res_delay   <= '0;
      r_res_len     <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_accept) begin
      r_got         <= 1'b0;
      r_res_delay   <= '0;
      r_res_len     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_first) begin
        r_got       <= 1'b1;
        r_res_delay <= sta.worst_delay;
        r_res_len   <= 5'd1;
      end else if (w_more && r_res_len != 5'd31) begin
        r_res_len   <= r_res_len + 5'd1;
      end
      if (w_expire) r_timeout_err <= 1'b1;
    end
  end

  // Status flags follow the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

`ifdef STA_TX_PATH_CHECK_EN
  logic       r_path_first_bad;
  logic [3:0] r_path_last;
  logic       r_path_err;

  // Path protocol: result must open with node 0 and close with node 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_path_first_bad <= 1'b0;
      r_path_last      <= '0;
      r_path_err       <= 1'b0;
    end else if (w_accept) begin
      r_path_first_bad <= 1'b0;
      r_path_last      <= '0;
      r_path_err       <= 1'b0;
    end else begin
      if (w_first) r_path_first_bad <= (sta.path != 4'd0);
      if (w_first || w_more) r_path_last <= sta.path;
      if (w_fall && (r_path_first_bad || r_path_last != 4'd1)) r_path_err <= 1'b1;
    end
  end

  assign o_path_err = r_path_err;
`else
  assign o_path_err = 1'b0;
`endif

  assign sta.in_valid    = r_in_valid;
  assign sta.delay       = r_delay;
  assign sta.source      = r_source;
  assign sta.destination = r_destination;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_timeout_err   = r_timeout_err;
  assign o_res_delay     = r_res_delay;
  assign o_res_len       = r_res_len;

endmodule

// File: tb/tb_sta_frame_tx.sv
// tb_sta_frame_tx: directed bench for sta_frame_tx. A table model plus the
// launch cycle give the expected frame/busy/done for every cycle.
module tb_sta_frame_tx;
  localparam int NODES   = 16;
  localparam int EDGES   = 32;
  localparam int TIMEOUT = 1023;

`ifdef STA_TX_PATH_CHECK_EN
  localparam logic EXP_PERR_BAD = 1'b1;
`else
  localparam logic EXP_PERR_BAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_wr_en = 1'b0;
  logic       i_wr_sel = 1'b0;
  logic [4:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0;
  logic       i_start = 1'b0;
  logic       o_busy, o_done, o_timeout_err, o_path_err;
  logic [7:0] o_res_delay;
  logic [4:0] o_res_len;

  sta_frame_tx_if sif();

  sta_frame_tx #(.NODES(NODES), .EDGES(EDGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_timeout_err(o_timeout_err),
    .o_res_delay(o_res_delay), .o_res_len(o_res_len), .o_path_err(o_path_err),
    .sta(sif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nfail = 0;

  logic [3:0] m_dly  [NODES];
  logic [7:0] m_edge [EDGES];
  bit         active = 1'b0;
  bit         chk_on = 1'b0;
  int         launch_cyc = 0;
  int         done_w = 0;
  int         done_cnt = 0;
  int         iv_cnt = 0;
  logic [3:0] cap_dly [64];
  logic [3:0] cap_src [64];
  logic [3:0] cap_dst [64];
  logic [7:0] resp_wd   [64];
  logic [3:0] resp_path [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the frame model.
  always @(negedge clk) begin : cmp
    int         w;
    bit         eiv;
    bit         ebusy;
    bit         edone;
    logic [4:0] k5;
    logic [3:0] k4;
    logic [3:0] ed, es, et;
    if (chk_on) begin
      w     = cyc - launch_cyc;
      k5    = 5'(w);
      k4    = 4'(w);
      eiv   = active && (w >= 0) && (w < EDGES);
      ebusy = active && (w >= 0) && (w <= done_w);
      edone = active && (w == done_w);
      ed    = (eiv && w < NODES) ? m_dly[k4] : 4'd0;
      es    = eiv ? m_edge[k5][7:4] : 4'd0;
      et    = eiv ? m_edge[k5][3:0] : 4'd0;
      chk("in_valid",    32'(sif.in_valid),    32'(eiv));
      chk("delay",       32'(sif.delay),       32'(ed));
      chk("source",      32'(sif.source),      32'(es));
      chk("destination", 32'(sif.destination), 32'(et));
      chk("busy",        32'(o_busy),          32'(ebusy));
      chk("done",        32'(o_done),          32'(edone));
      if (active && w >= 0 && w < 64) begin
        cap_dly[6'(w)] = sif.delay;
        cap_src[6'(w)] = sif.source;
        cap_dst[6'(w)] = sif.destination;
      end
      if (sif.in_valid) iv_cnt++;
      if (o_done) done_cnt++;
    end
  end

  task automatic wr(input bit sel, input int addr, input logic [7:0] data);
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_sel = sel; i_wr_addr = 5'(addr); i_wr_data = data;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    if (!sel && addr < NODES) m_dly[4'(addr)] = data[3:0];
    else if (sel && addr < EDGES) m_edge[5'(addr)] = data;
  endtask

  task automatic load_tables();
    int k1;
    for (int i = 0; i < NODES; i++) wr(1'b0, i, 8'(i));
    for (int k = 0; k < EDGES; k++) begin
      k1 = k + 1;
      wr(1'b1, k, {4'(k), 4'(k1)});
    end
  endtask

  // Launch a frame, answer with ov_n result cycles starting at window ov_w (0 = none).
  task automatic run_frame(input int ov_w, input int ov_n, input bit glitch, input bit poke);
    int w;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    launch_cyc = cyc;
    iv_cnt = 0;
    done_w = (ov_n == 0) ? (EDGES + TIMEOUT) : (ov_w + ov_n + 1);
    active = 1'b1;
    chk("accept_clr_res_len",   32'(o_res_len),     32'd0);
    chk("accept_clr_res_delay", 32'(o_res_delay),   32'd0);
    chk("accept_clr_timeout",   32'(o_timeout_err), 32'd0);
    chk("accept_clr_path_err",  32'(o_path_err),    32'd0);
    for (int t = 0; t <= done_w + 1; t++) begin
      @(negedge clk);
      w = cyc - launch_cyc;
      if (ov_n > 0 && w >= ov_w && w < ov_w + ov_n) begin
        sif.out_valid   = 1'b1;
        sif.worst_delay = resp_wd[6'(w - ov_w)];
        sif.path        = resp_path[6'(w - ov_w)];
      end else if (glitch && (w == 5 || w == 6)) begin
        sif.out_valid   = 1'b1;
        sif.worst_delay = 8'd200;
        sif.path        = 4'd9;
      end else begin
        sif.out_valid   = 1'b0;
        sif.worst_delay = 8'd0;
        sif.path        = 4'd0;
      end
      if (poke) begin
        i_wr_en   = (w == 2) || (w == EDGES + 2);
        i_wr_sel  = (w == EDGES + 2);
        i_wr_addr = 5'd3;
        i_wr_data = (w == 2) ? 8'h0F : 8'hFF;
        i_start   = (w == 8) || (w == EDGES + 1) || (w == done_w);
      end
    end
    @(posedge clk); #1;
    active  = 1'b0;
    i_start = 1'b0;
    i_wr_en = 1'b0;
  endtask

  initial begin
    int dc;
    sif.out_valid = 1'b0; sif.worst_delay = '0; sif.path = '0;
    for (int i = 0; i < NODES; i++) m_dly[i] = '0;
    for (int i = 0; i < EDGES; i++) m_edge[i] = '0;
    chk_on = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      32'(o_busy),        32'd0);
    chk("rst_done",      32'(o_done),        32'd0);
    chk("rst_in_valid",  32'(sif.in_valid),  32'd0);
    chk("rst_res_len",   32'(o_res_len),     32'd0);
    chk("rst_res_delay", 32'(o_res_delay),   32'd0);
    chk("rst_timeout",   32'(o_timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of SEND abandons the frame.
    load_tables();
    wr(1'b0, 20, 8'h07);
    dc = done_cnt;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    launch_cyc = cyc;
    done_w = EDGES + TIMEOUT;
    active = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    active = 1'b0;
    #1;
    chk("midrst_in_valid", 32'(sif.in_valid), 32'd0);
    chk("midrst_busy",     32'(o_busy),       32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NODES; i++) m_dly[i] = '0;
    for (int i = 0; i < EDGES; i++) m_edge[i] = '0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);

    // Cleared tables, no response: timeout.
    dc = done_cnt;
    run_frame(0, 0, 1'b0, 1'b0);
    chk("tmo_err",       32'(o_timeout_err),   32'd1);
    chk("tmo_res_len",   32'(o_res_len),       32'd0);
    chk("tmo_res_delay", 32'(o_res_delay),     32'd0);
    chk("tmo_path_err",  32'(o_path_err),      32'd0);
    chk("tmo_done_cnt",  32'(done_cnt - dc),   32'd1);

    // Normal frame, 4-cycle result, out_valid glitch during SEND ignored.
    load_tables();
    wr(1'b0, 20, 8'h07);
    resp_wd[0] = 8'd27; resp_wd[1] = 8'd99; resp_wd[2] = 8'd55; resp_wd[3] = 8'd200;
    resp_path[0] = 4'd0; resp_path[1] = 4'd5; resp_path[2] = 4'd5; resp_path[3] = 4'd1;
    dc = done_cnt;
    run_frame(EDGES + 3, 4, 1'b1, 1'b0);
    chk("f_iv_cnt",    32'(iv_cnt),      32'd32);
    chk("f_c3_delay",  32'(cap_dly[3]),  32'd3);
    chk("f_c3_src",    32'(cap_src[3]),  32'd3);
    chk("f_c3_dst",    32'(cap_dst[3]),  32'd4);
    chk("f_c20_delay", 32'(cap_dly[20]), 32'd0);
    chk("f_c20_src",   32'(cap_src[20]), 32'd4);
    chk("f_c20_dst",   32'(cap_dst[20]), 32'd5);
    chk("f_res_delay", 32'(o_res_delay), 32'd27);
    chk("f_res_len",   32'(o_res_len),   32'd4);
    chk("f_timeout",   32'(o_timeout_err), 32'd0);
    chk("f_path_err",  32'(o_path_err),  32'd0);
    chk("f_done_cnt",  32'(done_cnt - dc), 32'd1);

    // Writes/starts while busy ignored; result begins in first WAIT cycle; bad path.
    resp_wd[0] = 8'h80; resp_wd[1] = 8'h01; resp_wd[2] = 8'h02;
    resp_path[0] = 4'd2; resp_path[1] = 4'd5; resp_path[2] = 4'd1;
    dc = done_cnt;
    run_frame(EDGES, 3, 1'b0, 1'b1);
    chk("b_res_delay", 32'(o_res_delay), 32'h80);
    chk("b_res_len",   32'(o_res_len),   32'd3);
    chk("b_path_err",  32'(o_path_err),  32'(EXP_PERR_BAD));
    chk("b_done_cnt",  32'(done_cnt - dc), 32'd1);
    chk("b_c3_delay",  32'(cap_dly[3]),  32'd3);

    // Write together with start: write lands, no launch.
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = 5'd5; i_wr_data = 8'h09; i_start = 1'b1;
    @(posedge clk); #1;
    i_wr_en = 1'b0; i_start = 1'b0;
    m_dly[5] = 4'd9;
    repeat (3) @(negedge clk);
    chk("ws_no_busy", 32'(o_busy), 32'd0);

    // Long result saturates res_len; results hold after done.
    resp_wd[0] = 8'h11;
    resp_path[0] = 4'd0;
    for (int i = 1; i < 40; i++) begin
      resp_wd[i]   = 8'h22;
      resp_path[i] = (i == 39) ? 4'd1 : 4'd7;
    end
    dc = done_cnt;
    run_frame(EDGES + 1, 40, 1'b0, 1'b0);
    chk("s_c5_delay",  32'(cap_dly[5]),  32'd9);
    chk("s_res_len",   32'(o_res_len),   32'd31);
    chk("s_res_delay", 32'(o_res_delay), 32'h11);
    chk("s_path_err",  32'(o_path_err),  32'd0);
    chk("s_done_cnt",  32'(done_cnt - dc), 32'd1);
    repeat (5) @(negedge clk);
    chk("s_hold_len",   32'(o_res_len),   32'd31);
    chk("s_hold_delay", 32'(o_res_delay), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
